fx1_result_pipe: RTL and testbench

Result pipeline for the FX1 simple-fixed-point unit. It registers the 128-bit result of the combinational FX1 operators (compare, borrow/carry-generate, add/sub, logical), together with the target register address, through a fixed number of stages to the register-file write port. It also exposes every in-flight result to a three-source forwarding lookup used by operand fetch. It sits directly downstream of the FX1 operator mux and upstream of the register-file writeback arbiter.

---
 rtl/spu_pkg.sv | 14 +
 rtl/fx1_fwd_match.sv | 26 ++
 rtl/fx1_result_pipe.sv | 97 +++++++++
 tb/tb_fx1_result_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Constants and the per-stage record shared by the FX1, FX2 and byte result pipes.
package spu_pkg;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 7;

    // Data uses big-endian numbering: bit 0 is the MSB.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [0:DATA_W-1] data;
    } fx_stage_t;

endpackage

// File: rtl/fx1_fwd_match.sv
// Priority match of one operand address against every in-flight stage.
// The youngest matching stage supplies the data.
module fx1_fwd_match
    import spu_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  fx_stage_t         stage_i [STAGES],
    input  logic [ADDR_W-1:0] src_addr_i,
    output logic              hit_o,
    output logic [0:DATA_W-1] data_o
);

    // Scan from oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (stage_i[k].valid && (stage_i[k].addr == src_addr_i)) begin
                hit_o  = 1'b1;
                data_o = stage_i[k].data;
            end
        end
    end

endmodule

// File: rtl/fx1_result_pipe.sv
// FX1 result pipeline: carries results to register-file writeback and exposes
// every in-flight result to three operand-fetch forwarding lookups.
module fx1_result_pipe
    import spu_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic [0:DATA_W-1] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [0:DATA_W-1] wb_data,
    input  logic [ADDR_W-1:0] src_a_addr,
    input  logic [ADDR_W-1:0] src_b_addr,
    input  logic [ADDR_W-1:0] src_c_addr,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic              fwd_c_hit,
    output logic [0:DATA_W-1] fwd_a_data,
    output logic [0:DATA_W-1] fwd_b_data,
    output logic [0:DATA_W-1] fwd_c_data,
    output logic              busy
);

    // Index 0 is the youngest stage; index STAGES-1 drives writeback.
    fx_stage_t stage_q [STAGES];
    fx_stage_t stage_d [STAGES];

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_d[k].valid = 1'b0;
            end
        end else if (!stall) begin
            stage_d[0].valid = in_valid;
            stage_d[0].addr  = in_rt_addr;
            stage_d[0].data  = in_data;
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // A held result writes only on the cycle the stall releases.
    assign wb_we   = stage_q[STAGES-1].valid & ~stall & ~flush;
    assign wb_addr = stage_q[STAGES-1].addr;
    assign wb_data = stage_q[STAGES-1].data;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            busy = busy | stage_q[k].valid;
        end
    end

    fx1_fwd_match #(.STAGES(STAGES)) u_fwd_a (
        .stage_i    (stage_q),
        .src_addr_i (src_a_addr),
        .hit_o      (fwd_a_hit),
        .data_o     (fwd_a_data)
    );

    fx1_fwd_match #(.STAGES(STAGES)) u_fwd_b (
        .stage_i    (stage_q),
        .src_addr_i (src_b_addr),
        .hit_o      (fwd_b_hit),
        .data_o     (fwd_b_data)
    );

    fx1_fwd_match #(.STAGES(STAGES)) u_fwd_c (
        .stage_i    (stage_q),
        .src_addr_i (src_c_addr),
        .hit_o      (fwd_c_hit),
        .data_o     (fwd_c_data)
    );

endmodule

// File: tb/tb_fx1_result_pipe.sv
// Self-checking bench for fx1_result_pipe: directed scenarios then random traffic,
// compared each cycle against an age-based model of in-flight results.
module tb_fx1_result_pipe;

    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [6:0]   in_rt_addr = '0;
    logic [0:127] in_data = '0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         wb_we;
    logic [6:0]   wb_addr;
    logic [0:127] wb_data;
    logic [6:0]   src_a_addr = '0;
    logic [6:0]   src_b_addr = '0;
    logic [6:0]   src_c_addr = '0;
    logic         fwd_a_hit, fwd_b_hit, fwd_c_hit;
    logic [0:127] fwd_a_data, fwd_b_data, fwd_c_data;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    int mark;

    always #5 clk = ~clk;

    fx1_result_pipe #(.STAGES(STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_rt_addr (in_rt_addr),
        .in_data    (in_data),
        .stall      (stall),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .src_a_addr (src_a_addr),
        .src_b_addr (src_b_addr),
        .src_c_addr (src_c_addr),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_c_hit  (fwd_c_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data),
        .fwd_c_data (fwd_c_data),
        .busy       (busy)
    );

    // Model: each accepted result carries its age in advances (1 = just accepted);
    // it is written back while its age equals STAGES.
    typedef struct {
        bit [6:0]   a;
        bit [127:0] d;
        int         age;
    } result_t;
    result_t inflight[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void fwd_exp(input bit [6:0] src, output bit h, output bit [127:0] d);
        int best;
        best = STAGES + 1;
        h = 1'b0;
        d = '0;
        foreach (inflight[i]) begin
            if (inflight[i].a == src && inflight[i].age < best) begin
                best = inflight[i].age;
                h = 1'b1;
                d = inflight[i].d;
            end
        end
    endfunction

    task automatic check_outputs();
        bit         wv, h;
        bit [6:0]   wa;
        bit [127:0] wd, d;
        wv = 1'b0; wa = '0; wd = '0;
        foreach (inflight[i]) begin
            if (inflight[i].age == STAGES) begin
                wv = 1'b1; wa = inflight[i].a; wd = inflight[i].d;
            end
        end
        chk("wb_we", 128'(wb_we), 128'(wv & ~stall & ~flush));
        if (wv) begin
            chk("wb_addr", 128'(wb_addr), 128'(wa));
            chk("wb_data", wb_data, wd);
        end
        chk("busy", 128'(busy), 128'(inflight.size() != 0));
        fwd_exp(src_a_addr, h, d);
        chk("fwd_a_hit", 128'(fwd_a_hit), 128'(h));
        chk("fwd_a_data", fwd_a_data, d);
        fwd_exp(src_b_addr, h, d);
        chk("fwd_b_hit", 128'(fwd_b_hit), 128'(h));
        chk("fwd_b_data", fwd_b_data, d);
        fwd_exp(src_c_addr, h, d);
        chk("fwd_c_hit", 128'(fwd_c_hit), 128'(h));
        chk("fwd_c_data", fwd_c_data, d);
        if (wb_we === 1'b1) writes_seen++;
    endtask

    task automatic model_edge();
        result_t n;
        if (flush) begin
            inflight.delete();
        end else if (!stall) begin
            for (int i = inflight.size() - 1; i >= 0; i--) begin
                if (inflight[i].age == STAGES) inflight.delete(i);
            end
            foreach (inflight[i]) inflight[i].age++;
            if (in_valid) begin
                n.a = in_rt_addr; n.d = in_data; n.age = 1;
                inflight.push_back(n);
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [6:0] a, input logic [127:0] d,
                         input logic st, input logic fl,
                         input logic [6:0] sa, input logic [6:0] sb, input logic [6:0] sc);
        @(negedge clk);
        in_valid = v; in_rt_addr = a; in_data = d;
        stall = st; flush = fl;
        src_a_addr = sa; src_b_addr = sb; src_c_addr = sc;
        #2;
        check_outputs();
        $display("cyc v=%0b a=%0d st=%0b fl=%0b we=%0b wa=%0d hits=%0b%0b%0b busy=%0b",
                 v, a, st, fl, wb_we, wb_addr, fwd_a_hit, fwd_b_hit, fwd_c_hit, busy);
        @(posedge clk);
        model_edge();
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_wb_we"}, 128'(wb_we), 128'(0));
        chk({tag, "_wb_addr"}, 128'(wb_addr), 128'(0));
        chk({tag, "_wb_data"}, wb_data, 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_hits"}, 128'({fwd_a_hit, fwd_b_hit, fwd_c_hit}), 128'(0));
        chk({tag, "_fwd_data"}, fwd_a_data | fwd_b_data | fwd_c_data, 128'(0));
    endtask

    initial begin
        logic [127:0] data_a, data_b;
        data_a = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        data_b = 128'h0B0B_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;

        // Reset state
        src_a_addr = 7'd5; src_b_addr = 7'd0; src_c_addr = 7'd9;
        #3;
        check_reset_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single result: written once, two cycles later
        mark = writes_seen;
        cycle(1, 7'd5, 128'd1, 0, 0, 7'd5, 7'd0, 7'd0);
        cycle(0, 7'd0, 0,      0, 0, 7'd5, 7'd0, 7'd0);
        cycle(0, 7'd0, 0,      0, 0, 7'd5, 7'd0, 7'd0);
        cycle(0, 7'd0, 0,      0, 0, 7'd5, 7'd0, 7'd0);
        chk("single_write_count", 128'(writes_seen - mark), 128'(1));

        // Priority: the younger of two results to r9 wins
        cycle(1, 7'd9, data_a, 0, 0, 7'd0, 7'd9, 7'd0);
        cycle(1, 7'd9, data_b, 0, 0, 7'd0, 7'd9, 7'd0);
        cycle(0, 7'd0, 0,      0, 0, 7'd0, 7'd9, 7'd0);
        chk("priority_data", fwd_b_data, data_b);
        cycle(0, 7'd0, 0,      0, 0, 7'd0, 7'd9, 7'd0);
        cycle(0, 7'd0, 0,      0, 0, 7'd0, 7'd9, 7'd0);

        // Stall with a result in the last stage: exactly one write on release
        cycle(1, 7'd20, data_a, 0, 0, 7'd20, 7'd0, 7'd0);
        cycle(0, 7'd0,  0,      0, 0, 7'd20, 7'd0, 7'd0);
        mark = writes_seen;
        cycle(0, 7'd0,  0,      1, 0, 7'd20, 7'd0, 7'd0);
        cycle(0, 7'd0,  0,      1, 0, 7'd20, 7'd0, 7'd0);
        cycle(0, 7'd0,  0,      1, 0, 7'd20, 7'd0, 7'd0);
        chk("stall_no_write", 128'(writes_seen - mark), 128'(0));
        cycle(0, 7'd0,  0,      0, 0, 7'd20, 7'd0, 7'd0);
        cycle(0, 7'd0,  0,      0, 0, 7'd20, 7'd0, 7'd0);
        chk("stall_one_write", 128'(writes_seen - mark), 128'(1));

        // Flush with the third of three back-to-back results
        cycle(1, 7'd30, data_a, 0, 0, 7'd30, 7'd31, 7'd32);
        cycle(1, 7'd31, data_b, 0, 0, 7'd30, 7'd31, 7'd32);
        mark = writes_seen;
        cycle(1, 7'd32, 128'd3, 0, 1, 7'd30, 7'd31, 7'd32);
        cycle(0, 7'd0,  0,      0, 0, 7'd30, 7'd31, 7'd32);
        chk("flush_busy", 128'(busy), 128'(0));
        cycle(0, 7'd0,  0,      0, 0, 7'd30, 7'd31, 7'd32);
        chk("flush_no_write", 128'(writes_seen - mark), 128'(0));

        // Flush together with stall: flush wins
        cycle(1, 7'd40, data_a, 0, 0, 7'd40, 7'd0, 7'd0);
        cycle(0, 7'd0,  0,      0, 0, 7'd40, 7'd0, 7'd0);
        cycle(0, 7'd0,  0,      1, 1, 7'd40, 7'd0, 7'd0);
        cycle(0, 7'd0,  0,      0, 0, 7'd40, 7'd0, 7'd0);
        chk("flush_stall_busy", 128'(busy), 128'(0));

        // Reset mid-stream with two valid stages
        cycle(1, 7'd50, data_a, 0, 0, 7'd50, 7'd51, 7'd0);
        cycle(1, 7'd51, data_b, 0, 0, 7'd50, 7'd51, 7'd0);
        @(negedge clk);
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        inflight.delete();
        #1;
        check_reset_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        mark = writes_seen;
        cycle(0, 7'd0,  0,      0, 0, 7'd50, 7'd51, 7'd0);
        cycle(0, 7'd0,  0,      0, 0, 7'd50, 7'd51, 7'd0);
        chk("midreset_no_write", 128'(writes_seen - mark), 128'(0));
        cycle(1, 7'd52, data_b, 0, 0, 7'd52, 7'd0, 7'd0);
        cycle(0, 7'd0,  0,      0, 0, 7'd52, 7'd0, 7'd0);
        cycle(0, 7'd0,  0,      0, 0, 7'd52, 7'd0, 7'd0);

        // Three-source lookup: two in-flight hits, one miss
        cycle(1, 7'd60, data_a, 0, 0, 7'd60, 7'd61, 7'd62);
        cycle(1, 7'd61, data_b, 0, 0, 7'd60, 7'd61, 7'd62);
        cycle(0, 7'd0,  0,      0, 0, 7'd60, 7'd61, 7'd62);
        cycle(0, 7'd0,  0,      0, 0, 7'd61, 7'd60, 7'd0);

        // Random traffic on a narrow address range to stress priority matching
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 70,
                  7'($urandom_range(0, 7)),
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 5,
                  7'($urandom_range(0, 7)),
                  7'($urandom_range(0, 7)),
                  7'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
